// File: rtl/mem_arb_pkg.sv
// Shared definitions for memory port arbiters: one-hot request type and the
// round-robin pick function (rotate to pointer, take lowest, rotate back).
package mem_arb_pkg;

  localparam int MAX_REQ    = 8;
  localparam int MAX_RD_LAT = 4;

  typedef logic [MAX_REQ-1:0] req_onehot_t;

  function automatic req_onehot_t rr_pick(input int unsigned n, input logic [2:0] ptr,
                                          input req_onehot_t valid);
    req_onehot_t rot, res;
    int unsigned p;
    logic [2:0]  idx;
    logic        found;
    rot   = '0;
    res   = '0;
    found = 1'b0;
    p     = 32'(ptr);
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((p + i) % n);
      if (i < n) rot[3'(i)] = valid[idx];
    end
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 3'((p + i) % n);
      if (i < n && rot[3'(i)] && !found) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick_onehot.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N. Also intended for the write-port arbiter.
module rr_pick_onehot
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  assign grant_o = N'(rr_pick(N, 3'(ptr_i), MAX_REQ'(valid_i)));

endmodule

// File: rtl/mem_rd_port_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among N_REQ requesters, with a
// fixed-latency grant pipeline routing read data back to the winner.
// Optional MEM_RD_ARB_CONFLICT_CNT_EN adds a saturating conflict counter output.
module mem_rd_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  output logic [N_REQ-1:0]    req_grant,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_rd_en,
  input  logic [DW-1:0]       mem_rd_data,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                busy
`ifdef MEM_RD_ARB_CONFLICT_CNT_EN
  ,output logic [15:0]        conflict_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]                 rr_ptr_q, rr_ptr_d, gidx;
  logic [RD_LAT-1:0][N_REQ-1:0]  gp_q;
  logic [N_REQ-1:0]              rsp_valid_q;
  logic [DW-1:0]                 rsp_data_q;

  rr_pick_onehot #(.N(N_REQ), .PW(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (req_grant)
  );

  always_comb begin
    mem_addr = '0;
    gidx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_grant[i]) begin
        mem_addr = req_addr[i*AW +: AW];
        gidx     = PW'(i);
      end
    end
    rr_ptr_d = rr_ptr_q;
    // Explicit wrap so non-power-of-two N_REQ never lands on a dead index.
    if (|req_grant) rr_ptr_d = (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
  end

  assign mem_rd_en = |req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      gp_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gp_q[0]  <= req_grant;
      for (int k = 1; k < RD_LAT; k++) gp_q[k] <= gp_q[k-1];
      rsp_valid_q <= gp_q[RD_LAT-1];
      if (|gp_q[RD_LAT-1]) rsp_data_q <= mem_rd_data;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (|gp_q) | (|rsp_valid_q);

`ifdef MEM_RD_ARB_CONFLICT_CNT_EN
  logic [15:0]            conflict_cnt_q, conflict_cnt_d;
  logic [$clog2(N_REQ+1)-1:0] nreq;
  logic [16:0]            sum;

  always_comb begin
    nreq = '0;
    for (int i = 0; i < N_REQ; i++) nreq = nreq + $bits(nreq)'(req_valid[i]);
    sum            = {1'b0, conflict_cnt_q} + 17'(nreq) - 17'd1;
    conflict_cnt_d = conflict_cnt_q;
    if (nreq >= 2) conflict_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
